counter_scheduler: RTL and testbench
====================================

# counter_scheduler

Time-shares one CNT_W-bit binary up-counter among NREQ requesters. Each requester asks for an interval of len+1 counting cycles. A round-robin arbiter grants the counter to one requester at a time and runs the count from 0 to that requester's length. The block then pulses a per-requester done and moves on. It sits in front of the BinaryCounter datapath as its sequencing and arbitration controller.

## Interface
- NREQ, 4, number of requesters (2..8)
- CNT_W, 6, counter width; matches the counter's count output
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  request, one bit per requester; level-sensitive
- len  in  NREQ*CNT_W  terminal value per requester; requester i at bits [i*CNT_W +: CNT_W]
- grant  out  NREQ  one-hot owner of the counter; all-zero when idle
- busy  out  1  counter is allocated (state COUNT or DONE)
- count  out  CNT_W  current counter value
- result  out  1  terminal flag: high in COUNT while count == latched len
- done  out  NREQ  one-cycle completion pulse for the owning requester
- aborted  out  1  one-cycle abort pulse; tied 0 unless COUNT_SCHED_ABORT_EN

## Operation
- Reset values: state IDLE, grant=0, busy=0, count=0, result=0, done=0, aborted=0, round-robin pointer=0, len_q=0.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning upward from the pointer, wrapping past NREQ-1 to 0.
  - Next edge: set grant to that one-hot, latch its len slice into len_q, set count=0, go to COUNT.
  - If no req bit is set, stay in IDLE.
- COUNT:
  - If count == len_q, the next edge goes to DONE and count holds.
  - Otherwise count increments by 1.
  - count never exceeds len_q and never wraps. len=2^CNT_W-1 counts up to all-ones without overflow.
- DONE:
  - done = grant for exactly this one cycle.
  - Next edge: grant=0, count=0, pointer = (granted index + 1) mod NREQ, go to IDLE.
- len and req of the owner are ignored after the latch; changing len mid-count has no effect.
- Requests from other requesters during COUNT/DONE wait; they are evaluated in the following IDLE cycle.
- A requester holding req high through its done is re-granted only after all other pending requesters have been served (fairness).
- busy = (state != IDLE).

## Timing
- Let E0 be the edge at which IDLE samples a req.
- grant, busy and count=0 are visible after E0.
- count = k after edge E0+k.
- result is high during the cycle after E0+len.
- done is high during the cycle after E0+len+1.
- grant/busy fall after E0+len+2.
- Total ownership is len+2 cycles; len=0 gives 2 cycles.
- At least one IDLE cycle separates consecutive grants. Back-to-back grant period is len+3 cycles.
- Asynchronous reset mid-operation:
  - Outputs clear immediately.
  - No done or aborted pulse is emitted.
  - The pointer returns to 0.

## Configuration
- COUNT_SCHED_ABORT_EN defined:
  - In COUNT, if req of the owner is sampled low, the next edge returns to IDLE, clears grant and count, and pulses aborted for one cycle.
  - done is not pulsed.
  - The pointer advances as for a normal completion.
  - A req drop in DONE is ignored.
- Not defined:
  - req of the owner is ignored after grant.
  - aborted is constant 0.

## Test plan
- Reset, then req=4'b0001, len0=3 -> grant=0001 after E0; count 0,1,2,3; result high at count=3; done=0001 one cycle after E0+4; grant=0 after E0+5.
- req=4'b1111 held, all len=0 -> grants in order 0001, 0010, 0100, 1000, 0001, each lasting 2 cycles, with 1 IDLE cycle between grants.
- len0=63 (CNT_W=6) -> count reaches 6'b111111 without wrapping; done pulses; count returns to 0.
- During an active grant to requester 1 with len1=5, change len1 to 1 and raise req2 -> the count still runs to 5; requester 2 is granted only after requester 1's done plus one IDLE cycle.
- Assert reset while count=2 -> grant, busy, count and done are 0 immediately; the next req=4'b0100 is granted from pointer 0 (requester 2 wins).
- With COUNT_SCHED_ABORT_EN, drop req0 at count=1 of len0=10 -> aborted pulses one cycle, no done, grant clears; the next grant starts from requester 1.

Source files
------------

// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - round-robin time-sharing controller for one up-counter
// Optional owner-abort support is compiled in with COUNT_SCHED_ABORT_EN.
module counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [CNT_W-1:0]      count,
    output logic                  result,
    output logic [NREQ-1:0]       done,
    output logic                  aborted
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    next_ptr;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic [CNT_W-1:0] len_q;
    logic             owner_drop;
    logic             aborted_q;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!pick_vld && req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    assign next_ptr = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

`ifdef COUNT_SCHED_ABORT_EN
    assign owner_drop = (state == S_COUNT) && !req[owner];
`else
    assign owner_drop = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_COUNT;
            S_COUNT: begin
                if (owner_drop) begin
                    state_nxt = S_IDLE;
                end else if (count == len_q) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ownership, latched length, counter and pointer bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            owner     <= '0;
            ptr       <= '0;
            len_q     <= '0;
            count     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant <= NREQ'(1) << pick_idx;
                        owner <= pick_idx;
                        len_q <= len[int'(pick_idx)*CNT_W +: CNT_W];
                        count <= '0;
                    end
                end
                S_COUNT: begin
                    if (owner_drop) begin
                        grant     <= '0;
                        count     <= '0;
                        ptr       <= next_ptr;
                        aborted_q <= 1'b1;
                    end else if (count != len_q) begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE: begin
                    grant <= '0;
                    count <= '0;
                    ptr   <= next_ptr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state != S_IDLE);
        result  = (state == S_COUNT) && (count == len_q);
        done    = (state == S_DONE) ? grant : '0;
        aborted = aborted_q;
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - scoreboard bench for counter_scheduler
module tb_counter_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [23:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [5:0]  count;
    logic        result;
    logic [3:0]  done;
    logic        aborted;

    counter_scheduler #(.NREQ(4), .CNT_W(6)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .len     (len),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .result  (result),
        .done    (done),
        .aborted (aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] who;
        int         len;
        int         gap;
        bit         is_abort;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic push(input logic [3:0] who, input int l, input int gap, input bit ab);
        exp_t x;
        x.who = who; x.len = l; x.gap = gap; x.is_abort = ab;
        sb.push_back(x);
    endtask

    task automatic set_len(input int i, input int v);
        len[i*6 +: 6] = 6'(v);
    endtask

    // Monitor: compares DUT events against the head of the scoreboard.
    logic [3:0] prev_grant;
    int own_cyc, idle_cyc, res_n;
    bit chk_after;

    always @(negedge clock) begin
        if (reset) begin
            prev_grant = '0; own_cyc = 0; idle_cyc = 0; res_n = 0; chk_after = 0;
        end else begin
            if (chk_after) begin
                chk("post_grant", int'(grant), 0);
                chk("post_count", int'(count), 0);
                chk("post_busy", int'(busy), 0);
                chk_after = 0;
            end
            if (grant != 0 && prev_grant == 0) begin
                if (sb.size() == 0) begin
                    chk("grant_unexpected", int'(grant), 0);
                end else begin
                    chk("grant_who", int'(grant), int'(sb[0].who));
                    if (sb[0].gap >= 0) chk("idle_gap", idle_cyc, sb[0].gap);
                end
                own_cyc = 0;
                res_n   = 0;
            end else if (grant != 0) begin
                own_cyc++;
            end
            if (grant == 0) idle_cyc++; else idle_cyc = 0;
            if (result) res_n++;
            if (done != 0) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", int'(e.is_abort), 0);
                    chk("done_who", int'(done), int'(e.who));
                    chk("done_count", int'(count), e.len);
                    chk("done_latency", own_cyc, e.len + 1);
                    chk("result_cycles", res_n, 1);
                    chk_after = 1;
                end
            end
            if (aborted) begin
                if (sb.size() == 0) begin
                    chk("abort_unexpected", int'(aborted), 0);
                end else begin
                    e = sb.pop_front();
                    chk("abort_kind", int'(e.is_abort), 1);
                    chk("abort_who", int'(prev_grant), int'(e.who));
                    chk("abort_grant", int'(grant), 0);
                    chk("abort_count", int'(count), 0);
                    chk("abort_done", int'(done), 0);
                end
            end
            prev_grant = grant;
        end
    end

    task automatic wait_grants(input int n, input int budget);
        logic [3:0] p;
        int seen;
        p = grant;
        seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clock);
            if (grant != 0 && p == 0) seen++;
            p = grant;
        end
        if (seen < n) fail_now("wait_grants");
    endtask

    task automatic wait_count(input logic [3:0] g, input int v, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clock);
            if (grant == g && int'(count) == v) break;
        end
        if (c >= budget) fail_now("wait_count");
    endtask

    task automatic wait_drain(input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(posedge clock);
            if (sb.size() == 0) break;
        end
        if (c >= budget) begin
            fail_now("wait_drain");
            sb.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        repeat (3) @(negedge clock);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single request, len 3.
        set_len(0, 3);
        push(4'b0001, 3, -1, 0);
        req = 4'b0001;
        @(negedge clock);
        req = 4'b0000;
        wait_drain(50);

        // All four requesting with len 0: fair rotation from pointer 0.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        len = '0;
        push(4'b0001, 0, -1, 0);
        push(4'b0010, 0, 1, 0);
        push(4'b0100, 0, 1, 0);
        push(4'b1000, 0, 1, 0);
        push(4'b0001, 0, 1, 0);
        req = 4'b1111;
        wait_grants(5, 60);
        req = 4'b0000;
        wait_drain(50);

        // Full-scale length: count reaches all-ones without wrapping.
        set_len(0, 63);
        push(4'b0001, 63, -1, 0);
        req = 4'b0001;
        @(negedge clock);
        req = 4'b0000;
        wait_drain(120);

        // Mid-count len change is ignored; waiting requester follows after one idle cycle.
        set_len(1, 5);
        set_len(2, 2);
        push(4'b0010, 5, -1, 0);
        push(4'b0100, 2, 1, 0);
        req = 4'b0010;
        wait_grants(1, 20);
        req = 4'b0100;
        set_len(1, 1);
        wait_grants(1, 40);
        req = 4'b0000;
        wait_drain(50);

        // Reset in the middle of a count.
        set_len(3, 4);
        push(4'b1000, 4, -1, 0);
        req = 4'b1000;
        @(negedge clock);
        req = 4'b0000;
        wait_count(4'b1000, 2, 20);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_aborted", int'(aborted), 0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        set_len(2, 1);
        set_len(3, 3);
        push(4'b0100, 1, -1, 0);
        req = 4'b1100;
        @(negedge clock);
        req = 4'b0000;
        wait_drain(50);

`ifdef COUNT_SCHED_ABORT_EN
        // Owner drops its request mid-count.
        set_len(0, 10);
        set_len(1, 0);
        push(4'b0001, 10, -1, 1);
        push(4'b0010, 0, 1, 0);
        req = 4'b0001;
        wait_count(4'b0001, 1, 20);
        req = 4'b1010;
        wait_grants(1, 20);
        req = 4'b0000;
        wait_drain(50);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
